arcade_led_arbiter: RTL and testbench

- Front-end controller for the two arcade Pmod input ports: JB is player B and JC is player A.
- Synchronises and debounces every input bit and generates per-player press events.
- Arbitrates ownership of the 16-LED bar between the two players with a hold timer.
- Replaces the direct port-to-LED pass-through at board top level.

---
 rtl/arcade_led_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_arcade_led_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/arcade_led_arbiter.sv
// Arcade Pmod front end: synchronises and debounces JB (player B) and JC (player A),
// detects presses and arbitrates ownership of the 16-LED bar with a hold timer.
module arcade_led_arbiter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int HOLD_W          = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  JB,
  input  logic [7:0]  JC,
  output logic [15:0] led,
  output logic [1:0]  owner,
  output logic [7:0]  db_jb,
  output logic [7:0]  db_jc,
  output logic        press_jb,
  output logic        press_jc
);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_JB = 2'b01,
    OWN_JC = 2'b10
  } state_t;

  // Bit layout throughout: [15:8] = JC (player A), [7:0] = JB (player B).
  logic [15:0]     sync1_r;
  logic [15:0]     sync2_r;
  logic [15:0]     db_r;
  logic [15:0]     db_d_r;
  logic [DB_W-1:0] cnt_r [16];
  logic            press_jb_r;
  logic            press_jc_r;
  state_t          state_r;
  logic [HOLD_W-1:0] timer_r;
  logic            pending_r;
  logic            last_jc_r;
  logic [15:0]     led_r;
  logic [1:0]      owner_r;

  // Two-flop synchroniser on all sixteen asynchronous pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 16'h0000;
      sync2_r <= 16'h0000;
    end else begin
      sync1_r <= {JC, JB};
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debounce: a change is accepted only after DEBOUNCE_CYCLES stable mismatches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        cnt_r[i] <= '0;
      end
      db_r <= 16'h0000;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == DB_LAST) begin
          db_r[i]  <= sync2_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Rising-edge detect on the debounced buses, one pulse per rising cycle per player.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_d_r     <= 16'h0000;
      press_jb_r <= 1'b0;
      press_jc_r <= 1'b0;
    end else begin
      db_d_r     <= db_r;
      press_jb_r <= |(db_r[7:0] & ~db_d_r[7:0]);
      press_jc_r <= |(db_r[15:8] & ~db_d_r[15:8]);
    end
  end

  // Ownership arbiter; an owner press at timer expiry outranks a pending hand-over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      pending_r <= 1'b0;
      last_jc_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pending_r <= 1'b0;
          if (press_jb_r && press_jc_r) begin
            state_r <= last_jc_r ? OWN_JB : OWN_JC;
            timer_r <= HOLD_LOAD;
          end else if (press_jc_r) begin
            state_r <= OWN_JC;
            timer_r <= HOLD_LOAD;
          end else if (press_jb_r) begin
            state_r <= OWN_JB;
            timer_r <= HOLD_LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        OWN_JB: begin
          if (press_jb_r) begin
            timer_r   <= HOLD_LOAD;
            pending_r <= pending_r | press_jc_r;
          end else if (timer_r == '0) begin
            last_jc_r <= 1'b0;
            pending_r <= 1'b0;
            if (pending_r) begin
              state_r <= OWN_JC;
              timer_r <= HOLD_LOAD;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            timer_r   <= timer_r - HOLD_ONE;
            pending_r <= pending_r | press_jc_r;
          end
        end
        OWN_JC: begin
          if (press_jc_r) begin
            timer_r   <= HOLD_LOAD;
            pending_r <= pending_r | press_jb_r;
          end else if (timer_r == '0) begin
            last_jc_r <= 1'b1;
            pending_r <= 1'b0;
            if (pending_r) begin
              state_r <= OWN_JB;
              timer_r <= HOLD_LOAD;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            timer_r   <= timer_r - HOLD_ONE;
            pending_r <= pending_r | press_jb_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          timer_r   <= '0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // LED bar and owner code, registered one cycle behind the state and debounced data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_r   <= 16'h0000;
      owner_r <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          led_r   <= db_r;
          owner_r <= 2'b00;
        end
        OWN_JB: begin
          led_r   <= {db_r[7:0], db_r[7:0]};
          owner_r <= 2'b01;
        end
        OWN_JC: begin
          led_r   <= {db_r[15:8], db_r[15:8]};
          owner_r <= 2'b10;
        end
        default: begin
          led_r   <= 16'h0000;
          owner_r <= 2'b00;
        end
      endcase
    end
  end

  assign led      = led_r;
  assign owner    = owner_r;
  assign db_jb    = db_r[7:0];
  assign db_jc    = db_r[15:8];
  assign press_jb = press_jb_r;
  assign press_jc = press_jc_r;

endmodule

// File: tb/tb_arcade_led_arbiter.sv
// Directed bench for arcade_led_arbiter with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// Edge index ed counts rising clock edges since reset release (first sampling edge = 0).
module tb_arcade_led_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  JB = 8'h00;
  logic [7:0]  JC = 8'h00;
  logic [15:0] led;
  logic [1:0]  owner;
  logic [7:0]  db_jb;
  logic [7:0]  db_jc;
  logic        press_jb;
  logic        press_jc;

  int total = 0;
  int bad   = 0;
  int ed    = 0;

  always #5 clk = ~clk;

  arcade_led_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .DB_W(3),
    .HOLD_CYCLES(10),
    .HOLD_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .JB(JB),
    .JC(JC),
    .led(led),
    .owner(owner),
    .db_jb(db_jb),
    .db_jc(db_jc),
    .press_jb(press_jb),
    .press_jc(press_jc)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (ed=%0d)", tag, got, exp, ed);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ed++;
  endtask

  task automatic goto(input int e);
    while (ed < e) step();
  endtask

  task automatic enter_rst();
    rst_n = 1'b0;
    JB = 8'h00;
    JC = 8'h00;
    repeat (3) step();
  endtask

  task automatic release_rst(input logic [7:0] jb, input logic [7:0] jc);
    rst_n = 1'b1;
    JB = jb;
    JC = jc;
    ed = -1;
  endtask

  initial begin
    // 1: reset with all buttons held, then debounce latency
    JB = 8'hFF;
    JC = 8'hFF;
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("rst_led", led, 16'h0000);
      check_val("rst_owner", 16'(owner), 16'h0000);
      check_val("rst_db", {db_jc, db_jb}, 16'h0000);
      check_val("rst_press", {14'h0000, press_jc, press_jb}, 16'h0000);
    end
    release_rst(8'hFF, 8'hFF);
    goto(4);
    check_val("lat_db_early", 16'(db_jb), 16'h0000);
    goto(5);
    check_val("lat_db_jb", 16'(db_jb), 16'h00FF);
    check_val("lat_db_jc", 16'(db_jc), 16'h00FF);
    goto(6);
    check_val("lat_press", {14'h0000, press_jc, press_jb}, 16'h0003);

    // 2: three-cycle glitch on JC[3] is rejected
    enter_rst();
    release_rst(8'h00, 8'h08);
    goto(2);
    JC = 8'h00;
    for (int e = 3; e <= 12; e++) begin
      goto(e);
      check_val("glitch_db_jc", 16'(db_jc), 16'h0000);
      check_val("glitch_press", 16'(press_jc), 16'h0000);
      check_val("glitch_led", led, 16'h0000);
    end

    // 3: single JB press, ownership for exactly 10 cycles
    enter_rst();
    release_rst(8'h01, 8'h00);
    goto(6);
    check_val("p3_press_jb", 16'(press_jb), 16'h0001);
    goto(7);
    check_val("p3_press_once", 16'(press_jb), 16'h0000);
    check_val("p3_owner_pre", 16'(owner), 16'h0000);
    goto(8);
    check_val("p3_owner", 16'(owner), 16'h0001);
    check_val("p3_led", led, 16'h0101);
    goto(17);
    check_val("p3_owner_last", 16'(owner), 16'h0001);
    goto(18);
    check_val("p3_owner_idle", 16'(owner), 16'h0000);
    check_val("p3_led_idle", led, 16'h0001);

    // 4+5: simultaneous press -> JC; JB presses queue one hand-over
    enter_rst();
    release_rst(8'h01, 8'h01);
    goto(1);
    JB = 8'h03;
    goto(3);
    JB = 8'h07;
    goto(6);
    check_val("p4_press_both", {14'h0000, press_jc, press_jb}, 16'h0003);
    goto(8);
    check_val("p4_owner", 16'(owner), 16'h0002);
    check_val("p4_led", led, 16'h0101);
    check_val("p5_press_jb1", 16'(press_jb), 16'h0001);
    goto(10);
    check_val("p5_press_jb2", 16'(press_jb), 16'h0001);
    goto(17);
    check_val("p5_owner_hold", 16'(owner), 16'h0002);
    goto(18);
    check_val("p5_owner_handover", 16'(owner), 16'h0001);
    check_val("p5_led_handover", led, 16'h0707);
    goto(27);
    check_val("p5_owner_jb_last", 16'(owner), 16'h0001);
    goto(28);
    check_val("p5_owner_no_stack", 16'(owner), 16'h0000);
    check_val("p5_led_idle", led, 16'h0107);

    // 6: owner press at expiry beats pending, then reset mid-hold
    enter_rst();
    release_rst(8'h01, 8'h00);
    goto(1);
    JC = 8'h01;
    goto(8);
    check_val("p6_owner", 16'(owner), 16'h0001);
    goto(9);
    JB = 8'h03;
    goto(16);
    check_val("p6_press_at_zero", 16'(press_jb), 16'h0001);
    goto(18);
    check_val("p6_owner_reload", 16'(owner), 16'h0001);
    check_val("p6_led_reload", led, 16'h0303);
    goto(27);
    check_val("p6_owner_reload_last", 16'(owner), 16'h0001);
    goto(28);
    check_val("p6_owner_pending", 16'(owner), 16'h0002);
    check_val("p6_led_pending", led, 16'h0101);
    goto(30);
    rst_n = 1'b0;
    goto(31);
    check_val("p6_rst_owner", 16'(owner), 16'h0000);
    check_val("p6_rst_led", led, 16'h0000);
    check_val("p6_rst_db", {db_jc, db_jb}, 16'h0000);
    goto(32);
    check_val("p6_rst_hold_owner", 16'(owner), 16'h0000);
    check_val("p6_rst_press", {14'h0000, press_jc, press_jb}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
